// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: ROM request/response, redirect, and the 2-wide decode handshake.
// The master side is the fetch unit; the slave side is the ROM/decode environment.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_instruction_0;
  logic [DATA_WIDTH-1:0] rom_instruction_1;
  logic [1:0]            rom_valid;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [1:0]            dec_valid;
  logic [DATA_WIDTH-1:0] dec_instruction_0;
  logic [DATA_WIDTH-1:0] dec_instruction_1;
  logic [ADDR_WIDTH-1:0] dec_pc_0;
  logic [ADDR_WIDTH-1:0] dec_pc_1;
  logic [1:0]            dec_ready;
  logic                  fetch_done;

  modport master (
    output rom_addr, dec_valid, dec_instruction_0, dec_instruction_1, dec_pc_0, dec_pc_1,
           fetch_done,
    input  rom_instruction_0, rom_instruction_1, rom_valid, redirect_valid, redirect_pc,
           dec_ready
  );

  modport slave (
    input  rom_addr, dec_valid, dec_instruction_0, dec_instruction_1, dec_pc_0, dec_pc_1,
           fetch_done,
    output rom_instruction_0, rom_instruction_1, rom_valid, redirect_valid, redirect_pc,
           dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Dual-word instruction fetch front end: requests pairs from the ROM, tags them with PCs,
// buffers them in an in-order queue and hands them to decode two at a time.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = '0,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [QUEUE_DEPTH];

  logic [1:0]      n_req, n_enq, consumed, dec_valid;
  logic [CntW-1:0] free;
  logic            enq;

  // Redirect PCs are word aligned; the dropped offset bits are intentionally unused.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Request size from the ROM slot valids; a lone slot-1 word is not fetchable.
  always_comb begin
    n_req = 2'd0;
    if (bus.rom_valid == 2'b11)     n_req = 2'd2;
    else if (bus.rom_valid[0])      n_req = 2'd1;
    // Free space is taken before this cycle's dequeue, so a full queue stalls one extra cycle.
    free  = CntW'(QUEUE_DEPTH) - count_q;
    enq   = (state_q == StRun) && !bus.redirect_valid && (n_req != 2'd0) &&
            (free >= CntW'(n_req));
    n_enq = enq ? n_req : 2'd0;
  end

  // Decode handshake: slot 1 only counts when slot 0 is taken in the same cycle.
  always_comb begin
    dec_valid = {(count_q >= CntW'(2)), (count_q >= CntW'(1))} & ~{2{bus.redirect_valid}};
    consumed  = {1'b0, dec_valid[0] & bus.dec_ready[0]} +
                {1'b0, dec_valid[1] & bus.dec_ready[1] & bus.dec_ready[0]};
  end

  // Next-state for FSM, PC, queue pointers and the done flag; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q + PtrW'(consumed);
    tail_d  = tail_q + PtrW'(n_enq);
    count_d = count_q + CntW'(n_enq) - CntW'(consumed);
    done_d  = (state_q == StDrain) && (count_q == '0);
    if (enq) pc_d = pc_q + ADDR_WIDTH'({n_enq, 2'b00});
    if (state_q == StRun && !bus.rom_valid[0]) state_d = StDrain;
    if (bus.redirect_valid) begin
      state_d = StRun;
      pc_d    = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= BOOT_ADDR;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Queue storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[tail_q] <= bus.rom_instruction_0;
      pc_mem[tail_q]    <= pc_q;
      if (n_req == 2'd2) begin
        instr_mem[tail_q + PtrW'(1)] <= bus.rom_instruction_1;
        pc_mem[tail_q + PtrW'(1)]    <= pc_q + ADDR_WIDTH'(4);
      end
    end
  end

  assign bus.rom_addr          = pc_q;
  assign bus.dec_valid         = dec_valid;
  assign bus.dec_instruction_0 = instr_mem[head_q];
  assign bus.dec_instruction_1 = instr_mem[head_q + PtrW'(1)];
  assign bus.dec_pc_0          = pc_mem[head_q];
  assign bus.dec_pc_1          = pc_mem[head_q + PtrW'(1)];
  assign bus.fetch_done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of cycle-by-cycle expectations plus
// hand-written sequences for back-pressure, single-slot decode and mid-cycle reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] end_addr;

  fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BOOT_ADDR  (32'h0),
    .QUEUE_DEPTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  // ROM model: combinational read, slot k valid while its address is below END.
  always_comb begin
    bus.rom_instruction_0 = insn_of(bus.rom_addr);
    bus.rom_instruction_1 = insn_of(bus.rom_addr + 32'd4);
    bus.rom_valid         = {(bus.rom_addr + 32'd4 < end_addr), (bus.rom_addr < end_addr)};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fresh;
    logic [31:0] end_a;
    logic [1:0]  ready;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] ex_addr;
    logic [1:0]  ex_dv;
    logic [31:0] ex_pc0;
    logic [31:0] ex_pc1;
    logic        ex_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit f, logic [31:0] e, logic [1:0] r, logic rd, logic [31:0] rp,
                              logic [31:0] a, logic [1:0] dv, logic [31:0] p0, logic [31:0] p1,
                              logic d);
    vec_t v;
    v.fresh = f; v.end_a = e; v.ready = r; v.redir = rd; v.rpc = rp;
    v.ex_addr = a; v.ex_dv = dv; v.ex_pc0 = p0; v.ex_pc1 = p1; v.ex_done = d;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [1:0] r, input logic rd, input logic [31:0] rp);
    bus.dec_ready      = r;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rp;
  endtask

  task automatic chk_slots(input string tag, input logic [1:0] dv,
                           input logic [31:0] p0, input logic [31:0] p1);
    chk({tag, " dec_valid"}, 32'(bus.dec_valid), 32'(dv));
    if (dv[0]) begin
      chk({tag, " dec_pc_0"}, bus.dec_pc_0, p0);
      chk({tag, " dec_instruction_0"}, bus.dec_instruction_0, insn_of(p0));
    end
    if (dv[1]) begin
      chk({tag, " dec_pc_1"}, bus.dec_pc_1, p1);
      chk({tag, " dec_instruction_1"}, bus.dec_instruction_1, insn_of(p1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] got[$];
    logic [31:0] prev_addr;
    int          stalls;

    rst_n    = 1'b0;
    end_addr = 32'h0;
    set_in(2'b00, 1'b0, 32'h0);

    // Pairs to END=0x18, drain and done.
    vecs.push_back(mk(1, 32'h18, 2'b11, 0, 0, 32'h00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h18, 2'b11, 0, 0, 32'h08, 2'b11, 32'h00, 32'h04, 0));
    vecs.push_back(mk(0, 32'h18, 2'b11, 0, 0, 32'h10, 2'b11, 32'h08, 32'h0C, 0));
    vecs.push_back(mk(0, 32'h18, 2'b11, 0, 0, 32'h18, 2'b11, 32'h10, 32'h14, 0));
    vecs.push_back(mk(0, 32'h18, 2'b11, 0, 0, 32'h18, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h18, 2'b11, 0, 0, 32'h18, 2'b00, 0, 0, 1));
    vecs.push_back(mk(0, 32'h18, 2'b11, 0, 0, 32'h18, 2'b00, 0, 0, 1));
    // Odd-length program: trailing single word, then redirect out of DRAIN.
    vecs.push_back(mk(1, 32'h0C, 2'b11, 0, 0, 32'h00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h08, 2'b11, 32'h00, 32'h04, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h0C, 2'b01, 32'h08, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h0C, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h0C, 2'b00, 0, 0, 1));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 1, 32'h06, 32'h0C, 2'b00, 0, 0, 1));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h04, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h0C, 2'b11, 32'h04, 32'h08, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h0C, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0C, 2'b11, 0, 0, 32'h0C, 2'b00, 0, 0, 1));
    // Redirect with 4 queued entries and a misaligned target.
    vecs.push_back(mk(1, 32'h100, 2'b00, 0, 0, 32'h00, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 2'b00, 0, 0, 32'h08, 2'b11, 32'h00, 32'h04, 0));
    vecs.push_back(mk(0, 32'h100, 2'b11, 1, 32'h43, 32'h10, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 2'b11, 0, 0, 32'h40, 2'b00, 0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 2'b11, 0, 0, 32'h48, 2'b11, 32'h40, 32'h44, 0));
    vecs.push_back(mk(0, 32'h100, 2'b11, 0, 0, 32'h50, 2'b11, 32'h48, 32'h4C, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      end_addr = vecs[i].end_a;
      set_in(vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      if (vecs[i].fresh) do_reset();
      #1;
      chk({tag, " rom_addr"}, bus.rom_addr, vecs[i].ex_addr);
      chk({tag, " fetch_done"}, 32'(bus.fetch_done), 32'(vecs[i].ex_done));
      chk_slots(tag, vecs[i].ex_dv, vecs[i].ex_pc0, vecs[i].ex_pc1);
    end

    // Back-pressure: queue saturates at 8 entries, then releases in order.
    @(negedge clk);
    end_addr = 32'h100;
    set_in(2'b00, 1'b0, 32'h0);
    do_reset();
    for (int c = 1; c < 10; c++) @(negedge clk);
    #1;
    chk("full rom_addr", bus.rom_addr, 32'h20);
    chk("full dec_valid", 32'(bus.dec_valid), 32'h3);
    got.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      set_in(2'b11, 1'b0, 32'h0);
      #1;
      if (c < 2) chk($sformatf("release stall c%0d rom_addr", c), bus.rom_addr, 32'h20);
      if (bus.dec_valid[0]) got.push_back(bus.dec_pc_0);
      if (bus.dec_valid[1]) got.push_back(bus.dec_pc_1);
    end
    chk("release delivered count", 32'(got.size() >= 12), 32'h1);
    for (int k = 0; k < 12 && k < got.size(); k++)
      chk($sformatf("release order %0d", k), got[k], 32'(4 * k));

    // Single-slot decode: one instruction per cycle, fetch eventually stalls.
    @(negedge clk);
    set_in(2'b01, 1'b0, 32'h0);
    do_reset();
    #1;
    prev_addr = bus.rom_addr;
    stalls    = 0;
    for (int c = 1; c < 25; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("single c%0d dec_valid0", c), 32'(bus.dec_valid[0]), 32'h1);
      chk($sformatf("single c%0d dec_pc_0", c), bus.dec_pc_0, 32'(4 * (c - 1)));
      if (bus.rom_addr == prev_addr) stalls++;
      prev_addr = bus.rom_addr;
    end
    chk("single fetch stalled", 32'(stalls > 0), 32'h1);

    // Asynchronous reset between clock edges, then restart from boot.
    @(negedge clk);
    set_in(2'b11, 1'b0, 32'h0);
    do_reset();
    for (int c = 0; c < 3; c++) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("async rst rom_addr", bus.rom_addr, 32'h0);
    chk("async rst fetch_done", 32'(bus.fetch_done), 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post rst rom_addr", bus.rom_addr, 32'h0);
    chk_slots("post rst c0", 2'b00, 0, 0);
    @(negedge clk);
    #1;
    chk("post rst c1 rom_addr", bus.rom_addr, 32'h8);
    chk_slots("post rst c1", 2'b11, 32'h0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
